// File: rtl/fft_r2sdf_stage.sv
// Radix-2 single-path delay-feedback DIF butterfly stage with twiddle angle generation
// and quadrant pre-rotation for a downstream CORDIC rotator.
module fft_r2sdf_stage #(
  parameter int unsigned N_LOG2 = 8,
  parameter int unsigned STAGE  = 0,
  parameter int unsigned DW     = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          din_valid,
  input  logic          din_sop,
  input  logic [DW-1:0] din_re,
  input  logic [DW-1:0] din_im,
  output logic          dout_valid,
  output logic          dout_sop,
  output logic [DW-1:0] dout_re,
  output logic [DW-1:0] dout_im,
  output logic [15:0]   dout_theta
);

  localparam int unsigned D   = 2 ** (N_LOG2 - 1 - STAGE);
  localparam int unsigned CW  = N_LOG2 - STAGE;
  localparam int unsigned KW  = N_LOG2;
  localparam int unsigned DW1 = DW + 1;
  localparam int unsigned TW  = 16;
  localparam int unsigned AW  = (N_LOG2 + 10 > 18) ? N_LOG2 + 10 : 18;
  localparam logic signed [AW-1:0] NEG_QUARTER = AW'(-23040);

  logic [CW-1:0]  cnt, cnt_nxt, c_eff, m;
  logic           primed, primed_nxt;
  logic           fill, out_valid, out_sop, rot;
  logic [KW-1:0]  k;
  logic [AW-1:0]  prod;
  logic signed [AW-1:0]  raw, theta_w;
  logic signed [DW-1:0]  a_re, a_im, b_re, b_im;
  logic signed [DW-1:0]  sum_re, sum_im, dif_re, dif_im;
  logic signed [DW-1:0]  o_re, o_im, push_re, push_im;
  logic signed [DW1-1:0] sum_re_w, sum_im_w, dif_re_w, dif_im_w;
  logic signed [DW-1:0]  dl_re [D];
  logic signed [DW-1:0]  dl_im [D];

  // Butterfly, twiddle angle, quadrant fold and next-state decode
  always_comb begin
    c_eff      = din_sop ? '0 : cnt;
    fill       = ~c_eff[CW-1];
    m          = c_eff & CW'(D - 1);
    a_re       = dl_re[D-1];
    a_im       = dl_im[D-1];
    b_re       = din_re;
    b_im       = din_im;
    sum_re_w   = DW1'(a_re) + DW1'(b_re);
    sum_im_w   = DW1'(a_im) + DW1'(b_im);
    dif_re_w   = DW1'(a_re) - DW1'(b_re);
    dif_im_w   = DW1'(a_im) - DW1'(b_im);
    sum_re     = DW'(sum_re_w >>> 1);
    sum_im     = DW'(sum_im_w >>> 1);
    dif_re     = DW'(dif_re_w >>> 1);
    dif_im     = DW'(dif_im_w >>> 1);
    k          = fill ? (KW'(m) << STAGE) : '0;
    prod       = AW'(k) * AW'(360);
    raw        = -$signed(prod);
    rot        = fill && (raw < NEG_QUARTER);
    theta_w    = rot ? (raw - NEG_QUARTER) : raw;
    o_re       = fill ? a_re : sum_re;
    o_im       = fill ? a_im : sum_im;
    push_re    = fill ? b_re : dif_re;
    push_im    = fill ? b_im : dif_im;
    out_valid  = din_valid && (!fill || primed);
    out_sop    = out_valid && (c_eff == CW'(D));
    cnt_nxt    = cnt;
    primed_nxt = primed;

    // Angle beyond -90 deg: rotate data by -j so the CORDIC sees [-90, 0]
    if (rot) begin
      o_re = a_im;
      o_im = -a_re;
    end

    if (din_valid) begin
      cnt_nxt = c_eff + CW'(1);
      if (!fill) primed_nxt = 1'b1;
    end
  end

  // Half-block delay line; contents are don't-care until the first fill completes
  always_ff @(posedge clk) begin
    if (din_valid) begin
      dl_re[0] <= push_re;
      dl_im[0] <= push_im;
      for (int unsigned i = 1; i < D; i++) begin
        dl_re[i] <= dl_re[i-1];
        dl_im[i] <= dl_im[i-1];
      end
    end
  end

  // Block counter, priming flag and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      primed     <= 1'b0;
      dout_valid <= 1'b0;
      dout_sop   <= 1'b0;
      dout_re    <= '0;
      dout_im    <= '0;
      dout_theta <= '0;
    end else begin
      cnt        <= cnt_nxt;
      primed     <= primed_nxt;
      dout_valid <= out_valid;
      dout_sop   <= out_sop;
      if (out_valid) begin
        dout_re    <= o_re;
        dout_im    <= o_im;
        dout_theta <= TW'(theta_w);
      end
    end
  end

endmodule

// File: tb/tb_fft_r2sdf_stage.sv
// Bench for fft_r2sdf_stage: queue-based reference model compared every cycle,
// plus hand-computed literal expectations, on a D=128 and a D=1 instance.
module tb_fft_r2sdf_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        v0 = 1'b0, s0 = 1'b0, v1 = 1'b0, s1 = 1'b0;
  logic [15:0] re0 = '0, im0 = '0, re1 = '0, im1 = '0;
  logic        ov0, os0, ov1, os1;
  logic [15:0] ore0, oim0, oth0, ore1, oim1, oth1;

  fft_r2sdf_stage #(.N_LOG2(8), .STAGE(0), .DW(16)) u_s0 (
    .clk(clk), .rst_n(rst_n), .din_valid(v0), .din_sop(s0), .din_re(re0), .din_im(im0),
    .dout_valid(ov0), .dout_sop(os0), .dout_re(ore0), .dout_im(oim0), .dout_theta(oth0));

  fft_r2sdf_stage #(.N_LOG2(8), .STAGE(7), .DW(16)) u_s7 (
    .clk(clk), .rst_n(rst_n), .din_valid(v1), .din_sop(s1), .din_re(re1), .din_im(im1),
    .dout_valid(ov1), .dout_sop(os1), .dout_re(ore1), .dout_im(oim1), .dout_theta(oth1));

  int active = 0;
  logic        act_valid, act_sop;
  logic [15:0] act_re, act_im, act_th;
  always_comb begin
    act_valid = ov0; act_sop = os0; act_re = ore0; act_im = oim0; act_th = oth0;
    if (active != 0) begin
      act_valid = ov1; act_sop = os1; act_re = ore1; act_im = oim1; act_th = oth1;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  function automatic void chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: FIFO of the last D pushed values, integer block counter
  int   q_re[$];
  int   q_im[$];
  int   m_d = 128;
  int   m_stage = 0;
  int   m_cnt = 0;
  bit   m_primed = 1'b0;
  logic        e_valid = 1'b0, e_sop = 1'b0;
  logic [15:0] e_re = '0, e_im = '0, e_th = '0;

  function automatic void model_reset();
    q_re.delete();
    q_im.delete();
    for (int i = 0; i < m_d; i++) begin
      q_re.push_back(0);
      q_im.push_back(0);
    end
    m_cnt = 0; m_primed = 1'b0;
    e_valid = 1'b0; e_sop = 1'b0; e_re = '0; e_im = '0; e_th = '0;
  endfunction

  function automatic void model_step(input bit v, input bit sop, input int re, input int im);
    int c, hr, hi, o_r, o_i, k, raw, th, t;
    bit ov;
    if (!v) begin
      e_valid = 1'b0; e_sop = 1'b0;
      return;
    end
    c  = sop ? 0 : m_cnt;
    hr = q_re.pop_front();
    hi = q_im.pop_front();
    if (c < m_d) begin
      q_re.push_back(re); q_im.push_back(im);
      ov = m_primed; o_r = hr; o_i = hi;
      k = (c % m_d) * (1 << m_stage);
    end else begin
      o_r = (hr + re) >>> 1; o_i = (hi + im) >>> 1;
      q_re.push_back((hr - re) >>> 1); q_im.push_back((hi - im) >>> 1);
      m_primed = 1'b1; ov = 1'b1; k = 0;
    end
    raw = -360 * k;
    th  = raw;
    if (raw < -23040) begin
      t = o_r; o_r = o_i; o_i = -t; th = raw + 23040;
    end
    m_cnt   = (c + 1) % (2 * m_d);
    e_valid = ov;
    e_sop   = ov && (c == m_d);
    if (ov) begin
      e_re = 16'(o_r); e_im = 16'(o_i); e_th = 16'(th);
    end
  endfunction

  // Per-cycle compare, plus capture of the valid output sequence
  bit chk_en = 1'b0;
  int rec = 0;
  int vcount = 0;
  logic [47:0] ref_q[$];
  logic [47:0] gap_q[$];

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_valid", int'(act_valid), int'(e_valid));
      chk("cyc_sop",   int'(act_sop),   int'(e_sop));
      chk("cyc_re",    int'($signed(act_re)), int'($signed(e_re)));
      chk("cyc_im",    int'($signed(act_im)), int'($signed(e_im)));
      chk("cyc_theta", int'($signed(act_th)), int'($signed(e_th)));
      if (act_valid) begin
        vcount++;
        if (rec == 1) ref_q.push_back({act_re, act_im, act_th});
        else if (rec == 2) gap_q.push_back({act_re, act_im, act_th});
      end
    end
  end

  task automatic drive(input bit v, input bit sop, input int re, input int im);
    if (active == 0) begin
      v0 = v; s0 = sop; re0 = 16'(re); im0 = 16'(im);
    end else begin
      v1 = v; s1 = sop; re1 = 16'(re); im1 = 16'(im);
    end
    @(posedge clk);
    model_step(v, sop, re, im);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic lit(input string name, input int re, input int im, input int th);
    chk({name, "_valid"}, int'(act_valid), 1);
    chk({name, "_re"}, int'($signed(act_re)), re);
    chk({name, "_im"}, int'($signed(act_im)), im);
    chk({name, "_theta"}, int'($signed(act_th)), th);
  endtask

  function automatic int s2_val(input int i);
    if (i < 128) return 1000;
    if (i < 256) return -1000;
    return 0;
  endfunction

  initial begin
    int base, diffs, r;
    do_reset();
    chk_en = 1'b1;
    chk("reset_valid", int'(act_valid), 0);
    chk("reset_re", int'($signed(act_re)), 0);
    chk("reset_theta", int'($signed(act_th)), 0);

    // Constant input, D=128: silent fill then sums of 1000
    base = vcount;
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, i == 0, 1000, 0);
      if (i == 127) begin
        chk("s1_fill_silent", vcount - base, 0);
        chk("s1_fill_valid", int'(act_valid), 0);
      end
      if (i == 128) begin
        lit("s1_first_sum", 1000, 0, 0);
        chk("s1_first_sop", int'(act_sop), 1);
      end
    end
    drive(1'b0, 1'b0, 0, 0);
    chk("s1_count", vcount - base, 128);

    // +1000 block, -1000 block, then a zero block draining the differences
    do_reset();
    rec = 1;
    for (int i = 0; i < 384; i++) begin
      drive(1'b1, i == 0, s2_val(i), 0);
      case (i)
        128: begin lit("s2_sum0", 0, 0, 0); chk("s2_sum0_sop", int'(act_sop), 1); end
        256: lit("s2_m0", 1000, 0, 0);
        257: lit("s2_m1", 1000, 0, -360);
        320: lit("s2_m64", 1000, 0, -23040);
        321: lit("s2_m65", 0, -1000, -360);
        383: lit("s2_m127", 0, -1000, -22680);
        default: ;
      endcase
    end
    drive(1'b0, 1'b0, 0, 0);
    rec = 0;
    chk("s2_ref_len", ref_q.size(), 256);

    // Same stimulus with random idle gaps
    do_reset();
    rec = 2;
    for (int i = 0; i < 384; i++) begin
      r = int'($urandom_range(0, 5));
      repeat (r) drive(1'b0, 1'b0, 0, 0);
      drive(1'b1, i == 0, s2_val(i), 0);
    end
    drive(1'b0, 1'b0, 0, 0);
    rec = 0;
    chk("gap_len", gap_q.size(), ref_q.size());
    diffs = 0;
    for (int j = 0; j < gap_q.size() && j < ref_q.size(); j++)
      if (gap_q[j] != ref_q[j]) diffs++;
    chk("gap_seq_diffs", diffs, 0);

    // Reset pulsed mid-block
    do_reset();
    for (int i = 0; i < 200; i++) drive(1'b1, i == 0, 1000, 0);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_imm_valid", int'(act_valid), 0);
    chk("rst_imm_re", int'($signed(act_re)), 0);
    chk("rst_imm_sop", int'(act_sop), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    base = vcount;
    for (int i = 0; i < 128; i++) drive(1'b1, 1'b0, 1000, 0);
    chk("rst_fill_valid", int'(act_valid), 0);
    chk("rst_fill_silent", vcount - base, 0);
    drive(1'b1, 1'b0, 1000, 0);
    lit("rst_first_sum", 1000, 0, 0);
    chk("rst_first_sop", int'(act_sop), 1);

    // Last stage, D=1
    v0 = 1'b0; s0 = 1'b0;
    active = 1; m_d = 1; m_stage = 7;
    do_reset();
    drive(1'b1, 1'b1, 300, 40);
    chk("d1_first_valid", int'(act_valid), 0);
    drive(1'b1, 1'b0, 100, 20);
    lit("d1_sum", 200, 30, 0);
    drive(1'b1, 1'b0, 0, 0);
    lit("d1_diff", 100, 10, 0);
    drive(1'b1, 1'b0, 0, 0);
    drive(1'b1, 1'b0, 3, 0);
    drive(1'b1, 1'b0, -4, 0);
    lit("odd_sum", -1, 0, 0);
    drive(1'b1, 1'b0, 0, 0);
    lit("odd_diff", 3, 0, 0);
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 2));
      repeat (r) drive(1'b0, 1'b0, 0, 0);
      drive(1'b1, 1'b0, int'($urandom_range(0, 65535)) - 32768,
            int'($urandom_range(0, 65535)) - 32768);
    end
    drive(1'b0, 1'b0, 0, 0);
    drive(1'b0, 1'b0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
